stack_alu_sequencer: RTL
========================

// Module: stack_alu_sequencer
// PURPOSE
//  Sequences the datapath stack and ALU for one stack-machine ALU instruction.
//  Per accepted op: pops 1 or 2 operands, drives the ALU, pushes the result back.
//  Sits between the control unit (start/done handshake) and the datapath stack/ALU.
//  Frees the control unit from per-op micro-sequencing.
// PARAMETERS
//  DATA_W  8  width of stack words, ALU operands and result
//  OP_W    3  width of op select
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-low reset
//  start       in   1       op request, sampled only in IDLE
//  op          in   OP_W    0 AND, 1 OR, 2 NOT, 3 NAND, 4 XOR, 5 CMP, 6 ADD, 7 SUB
//  busy        out  1       high in every state except IDLE
//  done        out  1       one-cycle pulse; result pushed successfully
//  err         out  1       one-cycle pulse; op aborted
//  err_code    out  2       01 underflow, 10 overflow; held until next start
//  stack_dout  in   DATA_W  current TOS, combinational from stack
//  stack_empty in   1       stack has no entries
//  stack_full  in   1       stack has no free entry
//  stack_pop   out  1       pop strobe, one cycle
//  stack_push  out  1       push strobe, one cycle
//  stack_din   out  DATA_W  push data
//  alu_sel     out  OP_W    registered copy of op
//  alu_in1     out  DATA_W  older operand (second pop); zero for NOT
//  alu_in2     out  DATA_W  TOS operand (first pop)
//  alu_result  in   DATA_W  ALU result, combinational from alu_in1/alu_in2/alu_sel
//  alu_carry   in   1       ALU carry/borrow
//  carryOut    out  1       carry of last completed ADD/SUB; cleared by logic ops
// BEHAVIOUR
//  - Reset (any cycle, async): state IDLE; all outputs 0; an in-flight op is dropped with no push.
//  - FSM states: IDLE, POP1, POP2, EXEC, PUSH, DONE, ERR.
//  - IDLE: start=1 latches op into alu_sel and clears err_code, then goes to POP1. start while busy is ignored.
//  - POP1: if stack_empty, set err_code=01 and go to ERR. Else alu_in2<=stack_dout, pulse stack_pop,
//    then go to EXEC for NOT (alu_in1<=0) or to POP2 for all other ops.
//  - POP2: if stack_empty, set err_code=01 and go to ERR (first operand is discarded).
//    Else alu_in1<=stack_dout, pulse stack_pop, go to EXEC.
//  - EXEC: capture stack_din<=alu_result. carryOut<=alu_carry for ADD/SUB, else 0. Go to PUSH.
//  - PUSH: if stack_full, set err_code=10 and go to ERR with no push.
//    Else pulse stack_push, go to DONE.
//  - DONE: done=1 for one cycle, then IDLE.
//  - ERR: err=1 for one cycle, then IDLE. carryOut is unchanged on error.
//  - Latency from start edge to the done pulse:
//    binary ops done in the 5th cycle (IDLE->POP1->POP2->EXEC->PUSH->DONE);
//    NOT done in the 4th cycle.
//  - Back-to-back ops: start may be asserted in the cycle after DONE/ERR (IDLE).
//  - stack_pop and stack_push are never high in the same cycle and never high outside POP1/POP2/PUSH.
//  - CMP result is supplied by the ALU (+1 / -1 / 0, signed in1 vs in2) and pushed unchanged.
// CONFIGURATION
//  SEQ_UNDERFLOW_RESTORE_EN defined:
//    underflow detected in POP2 adds a RESTORE state that pushes the saved alu_in2 back
//    (one stack_push pulse), then goes to ERR. Stack depth ends unchanged; error latency +1 cycle.
//  Not defined: the first operand is discarded, and the stack ends one entry shallower.
// TESTING
//  1. Stack [0x0F,0xF0], op AND -> pops TOS 0xF0 then 0x0F; pushes 0x00; done in 5th cycle; carryOut=0.
//  2. Stack [0x0F], op NOT -> one pop, alu_in1=0, pushes 0xF0 (-16); done in 4th cycle.
//  3. Stack [0x4F,0x00] (TOS 0x00), op CMP -> in1=79, in2=0, pushes 0x01.
//     Stack [0x00,0x4F] -> pushes 0xFF (-1).
//  4. Stack [0xF0,0x20], op ADD -> pushes 0x10, carryOut=1. A following OR then clears carryOut.
//  5. Stack with one entry, op XOR -> err pulse, err_code=01, no push.
//     With SEQ_UNDERFLOW_RESTORE_EN: one push of the original TOS, and depth stays 1.
//  6. Assert reset (low) in EXEC -> busy=0, no push, all outputs 0.
//     After release, start with op OR on [0x0F,0x00] -> pushes 0x0F.

Source files
------------

// File: rtl/stack_alu_sequencer.sv
// Stack/ALU micro-sequencer: pops one or two operands, runs the ALU, pushes the result.
// Optional build macro SEQ_UNDERFLOW_RESTORE_EN re-pushes the first operand when the second pop underflows.
module stack_alu_sequencer #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [OP_W-1:0]   op,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   input  logic [DATA_W-1:0] stack_dout,
   input  logic              stack_empty,
   input  logic              stack_full,
   output logic              stack_pop,
   output logic              stack_push,
   output logic [DATA_W-1:0] stack_din,
   output logic [OP_W-1:0]   alu_sel,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry,
   output logic              carryOut
);

   localparam logic [OP_W-1:0] OP_NOT = OP_W'(2);
   localparam logic [OP_W-1:0] OP_ADD = OP_W'(6);
   localparam logic [OP_W-1:0] OP_SUB = OP_W'(7);

   localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
   localparam logic [1:0] ERR_OVERFLOW  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP1,
      S_POP2,
      S_EXEC,
      S_PUSH,
      S_DONE,
      S_ERR,
      S_RESTORE
   } state_t;

   state_t state, next_state;

   logic ld_op;
   logic ld_in2;
   logic ld_in1;
   logic clr_in1;
   logic ld_din;
   logic set_uflow;
   logic set_oflow;
   logic commit_carry;
   logic carry_pend;
`ifdef SEQ_UNDERFLOW_RESTORE_EN
   logic ld_restore;
`endif

   // NOTE: every combinational output gets a default before the case so no path can infer a latch.
   always_comb begin
      next_state   = state;
      busy         = (state != S_IDLE);
      done         = 1'b0;
      err          = 1'b0;
      stack_pop    = 1'b0;
      stack_push   = 1'b0;
      ld_op        = 1'b0;
      ld_in2       = 1'b0;
      ld_in1       = 1'b0;
      clr_in1      = 1'b0;
      ld_din       = 1'b0;
      set_uflow    = 1'b0;
      set_oflow    = 1'b0;
      commit_carry = 1'b0;
`ifdef SEQ_UNDERFLOW_RESTORE_EN
      ld_restore   = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               ld_op      = 1'b1;
               next_state = S_POP1;
            end
         end
         S_POP1: begin
            if (stack_empty) begin
               set_uflow  = 1'b1;
               next_state = S_ERR;
            end else begin
               stack_pop = 1'b1;
               ld_in2    = 1'b1;
               if (alu_sel == OP_NOT) begin
                  clr_in1    = 1'b1;
                  next_state = S_EXEC;
               end else begin
                  next_state = S_POP2;
               end
            end
         end
         S_POP2: begin
            if (stack_empty) begin
               set_uflow  = 1'b1;
`ifdef SEQ_UNDERFLOW_RESTORE_EN
               ld_restore = 1'b1;
               next_state = S_RESTORE;
`else
               next_state = S_ERR;
`endif
            end else begin
               stack_pop  = 1'b1;
               ld_in1     = 1'b1;
               next_state = S_EXEC;
            end
         end
         S_EXEC: begin
            ld_din     = 1'b1;
            next_state = S_PUSH;
         end
         S_PUSH: begin
            if (stack_full) begin
               set_oflow  = 1'b1;
               next_state = S_ERR;
            end else begin
               stack_push   = 1'b1;
               commit_carry = 1'b1;
               next_state   = S_DONE;
            end
         end
         S_DONE: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         S_ERR: begin
            err        = 1'b1;
            next_state = S_IDLE;
         end
`ifdef SEQ_UNDERFLOW_RESTORE_EN
         S_RESTORE: begin
            stack_push = 1'b1;
            next_state = S_ERR;
         end
`endif
         default: next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Carry is staged in EXEC and only becomes visible once the push succeeds,
   // so an aborted op leaves the last completed carry untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_sel    <= '0;
         alu_in1    <= '0;
         alu_in2    <= '0;
         stack_din  <= '0;
         err_code   <= 2'b00;
         carry_pend <= 1'b0;
         carryOut   <= 1'b0;
      end else begin
         if (ld_op) begin
            alu_sel  <= op;
            err_code <= 2'b00;
         end
         if (ld_in2) begin
            alu_in2 <= stack_dout;
         end
         if (clr_in1) begin
            alu_in1 <= '0;
         end
         if (ld_in1) begin
            alu_in1 <= stack_dout;
         end
         if (ld_din) begin
            stack_din  <= alu_result;
            carry_pend <= ((alu_sel == OP_ADD) || (alu_sel == OP_SUB)) ? alu_carry : 1'b0;
         end
         if (commit_carry) begin
            carryOut <= carry_pend;
         end
         if (set_uflow) begin
            err_code <= ERR_UNDERFLOW;
         end
         if (set_oflow) begin
            err_code <= ERR_OVERFLOW;
         end
`ifdef SEQ_UNDERFLOW_RESTORE_EN
         if (ld_restore) begin
            stack_din <= alu_in2;
         end
`endif
      end
   end

endmodule
